// File: rtl/bf_pkg.sv
// Shared types and defaults for the Bellman-Ford result drain stage.
package bf_pkg;

    localparam int          ADDR_W_DEF   = 13;
    localparam int          DIST_W_DEF   = 16;
    localparam logic [15:0] INF_DIST_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/bf_result_drain_if.sv
// Valid/ready stream carrying one distance beat with its node index.
interface bf_result_drain_if #(
    parameter int ADDR_W = 13,
    parameter int DIST_W = 16
);
    logic              valid;
    logic              ready;
    logic [DIST_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;

    modport master (output valid, data, index, last, input ready);
    modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/bf_drain_fifo.sv
// Small synchronous skid FIFO; push and pop in the same cycle are legal even when full.
module bf_drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             one
);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]    ONE_CNT  = (PW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [PW:0]      count_s;

    assign count_s = wr_ptr_r - rd_ptr_r;
    assign full    = (count_s == FULL_CNT);
    assign empty   = (count_s == {(PW+1){1'b0}});
    assign one     = (count_s == ONE_CNT);
    assign rdata   = mem_r[rd_ptr_r[PW-1:0]];

    // Storage and pointers; storage is cleared so a reset stream reads as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[PW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + ONE_CNT;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + ONE_CNT;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end
endmodule

// File: rtl/bf_result_drain.sv
// Streams the Bellman-Ford distance table out of the output memory with node indices.
// Optional running checksum of delivered distances when RESULT_CHECKSUM_EN is defined.
module bf_result_drain
    import bf_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DIST_W     = DIST_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DIST_W-1:0] INF_DIST   = INF_DIST_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    num_nodes,
    input  logic                 neg_cycle,
    output logic [ADDR_W-1:0]    OMAR,
    input  logic [DIST_W-1:0]    OMDR,
    bf_result_drain_if.master    out_if,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    unreach_cnt,
    output logic                 neg_flag
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DIST_W-1:0]    checksum
`endif
);
    localparam int                FW    = DIST_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    drain_state_e      state_r;
    drain_state_e      state_s;
    logic [ADDR_W-1:0] rd_idx_r;
    logic [ADDR_W-1:0] num_r;
    logic [ADDR_W-1:0] omar_r;
    logic [ADDR_W-1:0] unreach_r;
    logic              busy_r;
    logic              done_r;
    logic              neg_r;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              last_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_one_s;
    logic [FW-1:0]     wdata_s;
    logic [FW-1:0]     rdata_s;

    assign accept_s     = (state_r == ST_IDLE) && start;
    assign last_s       = (rd_idx_r == (num_r - ONE_A));
    assign wdata_s      = {OMDR, rd_idx_r, last_s};
    assign pop_s        = !fifo_empty_s && out_if.ready;
    assign out_if.valid = !fifo_empty_s;
    assign {out_if.data, out_if.index, out_if.last} = rdata_s;

    assign OMAR        = omar_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign unreach_cnt = unreach_r;
    assign neg_flag    = neg_r;

    bf_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .one   (fifo_one_s)
    );

    // Next-state and push decision.
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (neg_cycle || (num_nodes == {ADDR_W{1'b0}})) ? ST_DONE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // A full FIFO still takes a beat when the sink drains one this cycle.
                push_s = !fifo_full_s || pop_s;
                if (push_s && last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s || (fifo_one_s && pop_s)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decodes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Run parameters, read index and memory address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_r    <= {ADDR_W{1'b0}};
            neg_r    <= 1'b0;
            rd_idx_r <= {ADDR_W{1'b0}};
            omar_r   <= BASE_ADDR;
        end else if (accept_s) begin
            num_r    <= num_nodes;
            neg_r    <= neg_cycle;
            rd_idx_r <= {ADDR_W{1'b0}};
            omar_r   <= BASE_ADDR;
        end else if (push_s) begin
            rd_idx_r <= rd_idx_r + ONE_A;
            omar_r   <= BASE_ADDR + rd_idx_r + ONE_A;
        end else begin
            rd_idx_r <= rd_idx_r;
            omar_r   <= omar_r;
        end
    end

    // Saturating count of delivered unreachable distances.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unreach_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            unreach_r <= {ADDR_W{1'b0}};
        end else if (pop_s && (out_if.data == INF_DIST) && (unreach_r != {ADDR_W{1'b1}})) begin
            unreach_r <= unreach_r + ONE_A;
        end else begin
            unreach_r <= unreach_r;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DIST_W-1:0] sum_r;

    // Modular sum of delivered distances for the current run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_r <= {DIST_W{1'b0}};
        end else if (accept_s) begin
            sum_r <= {DIST_W{1'b0}};
        end else if (pop_s) begin
            sum_r <= sum_r + out_if.data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign checksum = sum_r;
`endif
endmodule

// File: tb/tb_bf_result_drain.sv
// Directed self-checking bench for bf_result_drain (checksum step when RESULT_CHECKSUM_EN is set).
module tb_bf_result_drain;
    import bf_pkg::*;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          neg_cycle = 1'b0;
    logic [AW-1:0] num_nodes = 13'd0;
    logic [AW-1:0] omar;
    logic [DW-1:0] omdr;
    logic          busy;
    logic          done;
    logic          neg_flag;
    logic [AW-1:0] unreach_cnt;
`ifdef RESULT_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif
    logic [DW-1:0] mem [8192];
    int            compared = 0;
    int            mismatched = 0;
    int            exp_unreach;

    bf_result_drain_if #(.ADDR_W(AW), .DIST_W(DW)) sif ();

    bf_result_drain #(
        .ADDR_W     (AW),
        .DIST_W     (DW),
        .BASE_ADDR  (13'd0),
        .FIFO_DEPTH (4),
        .INF_DIST   (16'hFFFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_nodes   (num_nodes),
        .neg_cycle   (neg_cycle),
        .OMAR        (omar),
        .OMDR        (omdr),
        .out_if      (sif),
        .busy        (busy),
        .done        (done),
        .unreach_cnt (unreach_cnt),
        .neg_flag    (neg_flag)
`ifdef RESULT_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clock = ~clock;
    assign omdr = mem[omar];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_run(input int n, input bit neg);
        @(negedge clock);
        num_nodes = AW'(n);
        neg_cycle = neg;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    // Consume beats until done (or until stop_after beats were accepted).
    task automatic run_drain(input int n, input bit toggle, input int stop_after, input int extra_start_at);
        int            exp_i = 0;
        bit            stalled = 1'b0;
        bit            seen_done = 1'b0;
        logic [DW-1:0] sd = 16'd0;
        logic [AW-1:0] si = 13'd0;
        for (int c = 0; c < 600 && !seen_done; c++) begin
            @(negedge clock);
            start = (c == extra_start_at);
            if (stalled) begin
                chk("stall_valid", 32'(sif.valid), 32'd1);
                chk("stall_data", 32'(sif.data), 32'(sd));
                chk("stall_index", 32'(sif.index), 32'(si));
            end
            chk("fifo_bound", 32'((int'(omar) - exp_i) <= 4 && (int'(omar) - exp_i) >= 0), 32'd1);
            if (done) begin
                seen_done = 1'b1;
                chk("beat_count", 32'(exp_i), 32'(n));
            end
            sif.ready = toggle ? (c % 2 == 0) : 1'b1;
            if (sif.valid && sif.ready) begin
                chk("beat_index", 32'(sif.index), 32'(exp_i));
                chk("beat_data", 32'(sif.data), 32'(mem[exp_i]));
                chk("beat_last", 32'(sif.last), 32'(exp_i == n - 1));
                exp_i++;
            end
            stalled = sif.valid && !sif.ready;
            sd = sif.data;
            si = sif.index;
            if (stop_after > 0 && exp_i == stop_after) begin
                return;
            end
        end
        if (!seen_done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        sif.ready = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = 16'd0;
        end

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(sif.valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_omar", 32'(omar), 32'd0);
        chk("rst_unreach", 32'(unreach_cnt), 32'd0);
        chk("rst_negflag", 32'(neg_flag), 32'd0);
        reset = 1'b1;

        // 1: five nodes, sink always ready, cycle-exact timing
        mem[0] = 16'd0; mem[1] = 16'd3; mem[2] = 16'hFFFF; mem[3] = 16'd7; mem[4] = 16'hFFFF;
        start_run(5, 1'b0);
        chk("t1_c1_valid", 32'(sif.valid), 32'd0);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        chk("t1_c1_omar", 32'(omar), 32'd0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clock);
            chk("t1_valid", 32'(sif.valid), 32'd1);
            chk("t1_index", 32'(sif.index), 32'(c - 2));
            chk("t1_data", 32'(sif.data), 32'(mem[c - 2]));
            chk("t1_last", 32'(sif.last), 32'(c == 6));
            chk("t1_done_early", 32'(done), 32'd0);
        end
        @(negedge clock);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_unreach", 32'(unreach_cnt), 32'd2);
        chk("t1_c7_valid", 32'(sif.valid), 32'd0);
        @(negedge clock);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: same data with the sink toggling ready
        start_run(5, 1'b0);
        run_drain(5, 1'b1, 0, -1);
        chk("t2_unreach", 32'(unreach_cnt), 32'd2);
        sif.ready = 1'b1;

        // 3: negative cycle run
        start_run(100, 1'b1);
        neg_cycle = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_negflag", 32'(neg_flag), 32'd1);
        chk("t3_valid", 32'(sif.valid), 32'd0);
        chk("t3_omar", 32'(omar), 32'd0);
        @(negedge clock);
        chk("t3_done_pulse", 32'(done), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_omar2", 32'(omar), 32'd0);
        chk("t3_valid2", 32'(sif.valid), 32'd0);

        // 4: zero nodes, then a 50-node run with an ignored start
        start_run(0, 1'b0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_unreach", 32'(unreach_cnt), 32'd0);
        chk("t4_negflag", 32'(neg_flag), 32'd0);
        chk("t4_valid", 32'(sif.valid), 32'd0);
        exp_unreach = 0;
        for (int i = 0; i < 50; i++) begin
            mem[i] = (i % 7 == 3) ? 16'hFFFF : 16'(i * 5);
            if (i % 7 == 3) exp_unreach++;
        end
        start_run(50, 1'b0);
        num_nodes = 13'd7;
        neg_cycle = 1'b1;
        run_drain(50, 1'b0, 0, 3);
        chk("t4_unreach50", 32'(unreach_cnt), 32'(exp_unreach));
        chk("t4_negflag50", 32'(neg_flag), 32'd0);
        neg_cycle = 1'b0;

        // 5: reset mid-run, then a clean rerun
        start_run(50, 1'b0);
        run_drain(50, 1'b0, 10, -1);
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(sif.valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_omar", 32'(omar), 32'd0);
        chk("t5_unreach", 32'(unreach_cnt), 32'd0);
        chk("t5_data", 32'(sif.data), 32'd0);
        chk("t5_index", 32'(sif.index), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        start_run(50, 1'b0);
        run_drain(50, 1'b0, 0, -1);
        chk("t5_unreach50", 32'(unreach_cnt), 32'(exp_unreach));

`ifdef RESULT_CHECKSUM_EN
        // 6: checksum wraps modulo 2^16
        mem[0] = 16'hFFFF;
        mem[1] = 16'h0002;
        start_run(2, 1'b0);
        run_drain(2, 1'b0, 0, -1);
        chk("t6_checksum", 32'(checksum), 32'h0001);
        @(negedge clock);
        chk("t6_checksum_hold", 32'(checksum), 32'h0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
